rs_aged: RTL

Age-ordered reservation station. It is the successor to the free-list RS. It holds up to `SIZE` dispatched micro-ops and wakes them on completion broadcasts. Each cycle it issues the oldest ready op to each of `P_COUNT` independently stalled issue ports, and each port is restricted to a set of FU types. It sits between dispatch/ROB and the FU issue stage, replacing index-order selection with true program-order (age) priority.

---
 rtl/rs_pkg.sv | 79 +++++++
 rtl/rs_aged_age_matrix.sv | 52 +++++
 rtl/rs_aged.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared types for the reservation stations: FU encoding, packets exchanged with
// dispatch, complete, issue and rewind, plus counter/index width helpers.
package rs_pkg;

  localparam int PHY_REG_W    = 6;
  localparam int ROB_IDX_W    = 5;
  localparam int SQ_IDX_W     = 4;
  localparam int XLEN         = 32;
  localparam int REWIND_N     = 4;
  localparam int REWIND_NUM_W = 3;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MEM  = 2'd1,
    FU_MULT = 2'd2,
    FU_BR   = 2'd3
  } fu_type_e;

  typedef logic [3:0] fu_mask_t;

  localparam fu_mask_t FU_MASK_ALU  = 4'b0001;
  localparam fu_mask_t FU_MASK_MEM  = 4'b0010;
  localparam fu_mask_t FU_MASK_MULT = 4'b0100;
  localparam fu_mask_t FU_MASK_BR   = 4'b1000;

  typedef struct packed {
    logic                 valid;
    logic [PHY_REG_W-1:0] idx;
  } phy_reg_t;

  typedef struct packed {
    fu_type_e   fu_type;
    logic [7:0] opcode;
  } decoded_inst_t;

  typedef struct packed {
    logic                 valid;
    decoded_inst_t        decoded_inst;
    phy_reg_t [1:0]       phy_src_reg;
    phy_reg_t             phy_dest_reg;
    logic [1:0]           ready;
    logic [ROB_IDX_W-1:0] rob_index;
    logic [XLEN-1:0]      pc;
    logic [SQ_IDX_W-1:0]  sq_index;
  } dispatch_packet_t;

  typedef struct packed {
    phy_reg_t phy_dest_reg;
  } complete_packet_t;

  typedef struct packed {
    logic                 valid;
    decoded_inst_t        decoded_inst;
    phy_reg_t [1:0]       phy_src_reg;
    phy_reg_t             phy_dest_reg;
    logic [ROB_IDX_W-1:0] rob_index;
    logic [XLEN-1:0]      pc;
    logic [SQ_IDX_W-1:0]  sq_index;
  } issue_packet_t;

  // Squash list driven by the ROB; only the first num slots are meaningful.
  typedef struct packed {
    logic [REWIND_NUM_W-1:0]                num;
    logic [REWIND_N-1:0][ROB_IDX_W-1:0]     rob_index;
  } rewind_t;

  function automatic int cal_cnt_len(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int cal_idx_len(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic fu_mask_t fu_to_mask(input fu_type_e fu);
    return fu_mask_t'(4'b0001 << fu);
  endfunction

endpackage

// File: rtl/rs_aged_age_matrix.sv
// Age matrix: older_r[i][j] set when busy entry j was dispatched before busy entry i.
// Picks the oldest entry of a request vector as a one-hot.
module rs_age_matrix
  import rs_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int D_WIDTH = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SIZE-1:0]              busy,
  input  logic [D_WIDTH-1:0]           insert_valid,
  input  logic [cal_idx_len(SIZE)-1:0] insert_idx [D_WIDTH],
  input  logic [SIZE-1:0]              free,
  input  logic [SIZE-1:0]              request,
  output logic [SIZE-1:0]              oldest
);

  logic [SIZE-1:0] older_r      [SIZE];
  logic [SIZE-1:0] older_next_s [SIZE];
  logic [SIZE-1:0] row_s;

  // New rows see every busy entry plus earlier lanes of the same cycle; freed columns clear
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      older_next_s[i] = older_r[i];
    end
    row_s = busy;
    for (int k = 0; k < D_WIDTH; k++) begin
      older_next_s[insert_idx[k]] = insert_valid[k] ? row_s : older_next_s[insert_idx[k]];
      row_s[insert_idx[k]]        = row_s[insert_idx[k]] | insert_valid[k];
    end
    for (int i = 0; i < SIZE; i++) begin
      older_next_s[i] = older_next_s[i] & ~free;
    end
  end

  // A requester is oldest when no other requester is older than it
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      oldest[i] = request[i] & ~(|(request & older_r[i]));
    end
  end

  // Matrix state register
  always_ff @(posedge clock) begin
    for (int i = 0; i < SIZE; i++) begin
      older_r[i] <= reset ? {SIZE{1'b0}} : older_next_s[i];
    end
  end

endmodule

// File: rtl/rs_aged.sv
// Age-ordered reservation station: lowest-free-first allocation, tag wakeup with
// dispatch bypass, and oldest-ready selection per FU-restricted issue port.
module rs_aged
  import rs_pkg::*;
#(
  parameter int       D_WIDTH = 3,
  parameter int       C_WIDTH = 3,
  parameter int       P_COUNT = 4,
  parameter int       SIZE    = 32,
  parameter fu_mask_t PORT_FU_MASK [P_COUNT] =
    '{FU_MASK_ALU | FU_MASK_MULT | FU_MASK_BR, FU_MASK_ALU, FU_MASK_MEM, FU_MASK_MULT}
) (
  input  logic                           clock,
  input  logic                           reset,
  input  dispatch_packet_t               dispatch [D_WIDTH],
  output logic [cal_cnt_len(D_WIDTH)-1:0] dispatch_empty_slots,
  input  complete_packet_t               complete [C_WIDTH],
  output issue_packet_t                  issue [P_COUNT],
  input  logic [P_COUNT-1:0]             port_ready,
  input  rewind_t                        rewind
);

  localparam int IDX_W = cal_idx_len(SIZE);
  localparam int CNT_W = cal_cnt_len(D_WIDTH);

  logic [SIZE-1:0]    busy_r;
  dispatch_packet_t   entry_r [SIZE];
  dispatch_packet_t   disp_s [D_WIDTH];
  logic [D_WIDTH-1:0] ins_valid_s;
  logic [IDX_W-1:0]   ins_idx_s [D_WIDTH];
  logic [CNT_W-1:0]   free_cnt_s;
  logic [1:0]         wake_s [SIZE];
  logic [SIZE-1:0]    ready_s;
  logic [SIZE-1:0]    rewound_s;
  logic [SIZE-1:0]    issued_s;
  logic [SIZE-1:0]    free_s;

  // Lowest-index-first selection of up to D_WIDTH free entries
  always_comb begin
    free_cnt_s = {CNT_W{1'b0}};
    for (int k = 0; k < D_WIDTH; k++) begin
      ins_idx_s[k] = {IDX_W{1'b0}};
    end
    for (int i = 0; i < SIZE; i++) begin
      if (!busy_r[i] && (free_cnt_s < CNT_W'(D_WIDTH))) begin
        ins_idx_s[free_cnt_s] = IDX_W'(i);
        free_cnt_s            = free_cnt_s + CNT_W'(1);
      end else begin
        free_cnt_s = free_cnt_s;
      end
    end
    for (int k = 0; k < D_WIDTH; k++) begin
      ins_valid_s[k] = dispatch[k].valid && (CNT_W'(k) < free_cnt_s);
    end
  end

  assign dispatch_empty_slots = free_cnt_s;

  // Dispatched sources hit by a same-cycle broadcast are stored ready
  always_comb begin
    for (int k = 0; k < D_WIDTH; k++) begin
      disp_s[k] = dispatch[k];
      for (int c = 0; c < C_WIDTH; c++) begin
        for (int s = 0; s < 2; s++) begin
          disp_s[k].ready[s] = disp_s[k].ready[s] |
            (complete[c].phy_dest_reg.valid &&
             (complete[c].phy_dest_reg.idx == dispatch[k].phy_src_reg[s].idx));
        end
      end
    end
  end

  // Per-entry rewind match, wakeup and issue request (rewind and reset veto issue)
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      rewound_s[i] = 1'b0;
      for (int j = 0; j < REWIND_N; j++) begin
        rewound_s[i] = rewound_s[i] |
          ((j < int'(rewind.num)) && (rewind.rob_index[j] == entry_r[i].rob_index));
      end
      rewound_s[i] = rewound_s[i] & busy_r[i];
      wake_s[i]    = 2'b00;
      for (int c = 0; c < C_WIDTH; c++) begin
        for (int s = 0; s < 2; s++) begin
          wake_s[i][s] = wake_s[i][s] |
            (complete[c].phy_dest_reg.valid &&
             (complete[c].phy_dest_reg.idx == entry_r[i].phy_src_reg[s].idx));
        end
      end
      ready_s[i] = busy_r[i] && (entry_r[i].ready == 2'b11) && !rewound_s[i] && !reset;
    end
  end

  for (genvar p = 0; p < P_COUNT; p++) begin : g_port
    logic [SIZE-1:0]  eligible_s;
    logic [SIZE-1:0]  grant_s;
    logic [SIZE-1:0]  claim_in_s;
    logic [SIZE-1:0]  claim_out_s;
    dispatch_packet_t sel_s;
    issue_packet_t    issue_s;

    if (p == 0) begin : g_first
      assign claim_in_s = {SIZE{1'b0}};
    end else begin : g_next
      assign claim_in_s = g_port[p-1].claim_out_s;
    end

    // Ready entries this port can execute that no higher-priority port has taken
    always_comb begin
      for (int i = 0; i < SIZE; i++) begin
        eligible_s[i] = ready_s[i] && !claim_in_s[i] &&
          (|(PORT_FU_MASK[p] & fu_to_mask(entry_r[i].decoded_inst.fu_type)));
      end
    end

    rs_age_matrix #(
      .SIZE    (SIZE),
      .D_WIDTH (D_WIDTH)
    ) u_age (
      .clock        (clock),
      .reset        (reset),
      .busy         (busy_r),
      .insert_valid (ins_valid_s),
      .insert_idx   (ins_idx_s),
      .free         (free_s),
      .request      (eligible_s),
      .oldest       (grant_s)
    );

    // A stalled port does not claim, so its candidate stays open to later ports
    assign claim_out_s = claim_in_s | (port_ready[p] ? grant_s : {SIZE{1'b0}});

    // One-hot mux of the granted entry onto the port
    always_comb begin
      sel_s = '0;
      for (int i = 0; i < SIZE; i++) begin
        sel_s = sel_s | (grant_s[i] ? entry_r[i] : '0);
      end
      issue_s = '0;
      if (port_ready[p] && sel_s.valid && (&sel_s.ready)) begin
        issue_s.valid        = 1'b1;
        issue_s.decoded_inst = sel_s.decoded_inst;
        issue_s.phy_src_reg  = sel_s.phy_src_reg;
        issue_s.phy_dest_reg = sel_s.phy_dest_reg;
        issue_s.rob_index    = sel_s.rob_index;
        issue_s.pc           = sel_s.pc;
        issue_s.sq_index     = sel_s.sq_index;
      end else begin
        issue_s = '0;
      end
    end

    assign issue[p] = issue_s;
  end

  assign issued_s = g_port[P_COUNT-1].claim_out_s;
  assign free_s   = issued_s | rewound_s;

  // Entry state: frees, wakeups, then inserts into slots that were free at cycle start
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= {SIZE{1'b0}};
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        busy_r[i]        <= busy_r[i] & ~free_s[i];
        entry_r[i].ready <= entry_r[i].ready | wake_s[i];
      end
      for (int k = 0; k < D_WIDTH; k++) begin
        if (ins_valid_s[k]) begin
          busy_r[ins_idx_s[k]]  <= 1'b1;
          entry_r[ins_idx_s[k]] <= disp_s[k];
        end
      end
    end
  end

endmodule
